// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register write arbiter: FSM encoding and index width.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW:0] k;

    always_comb begin
        pick = '0;
        idx  = '0;
        any  = 1'b0;
        k    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // One extra bit holds ptr+i before folding back into 0..N_REQ-1.
            k = {1'b0, ptr} + (IW+1)'(i);
            if (k >= (IW+1)'(N_REQ)) k = k - (IW+1)'(N_REQ);
            if (!any && req[k[IW-1:0]]) begin
                any             = 1'b1;
                pick[k[IW-1:0]] = 1'b1;
                idx             = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter serialising N_REQ writers onto one shared register,
// one write per two cycles (GRANT then ACK).
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int BW_DATA = 32,
    parameter int N_REQ   = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*BW_DATA-1:0]   i_data,
    output logic [N_REQ-1:0]           o_gnt,
    output logic [N_REQ-1:0]           o_ack,
    output logic [BW_DATA-1:0]         o_q,
    output logic [idx_w(N_REQ)-1:0]    o_owner,
    output logic                       o_valid,
    output logic                       o_busy
);

    localparam int IW = idx_w(N_REQ);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    pick_idx;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] pick;
    logic             pick_any;
    logic             wr_en;

    // A requester may still hold i_req in its ACK cycle; it must not win again.
    assign elig  = (state == ST_ACK) ? (i_req & ~o_ack) : i_req;
    assign wr_en = (state == ST_GRANT);

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req  (elig),
        .ptr  (ptr),
        .pick (pick),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            gnt_idx <= '0;
            o_gnt   <= '0;
            o_ack   <= '0;
            o_busy  <= 1'b0;
        end else begin
            o_ack <= '0;
            case (state)
                ST_GRANT: begin
                    state  <= ST_ACK;
                    o_ack  <= o_gnt;
                    o_gnt  <= '0;
                    o_busy <= 1'b1;
                end
                default: begin
                    if (pick_any) begin
                        state   <= ST_GRANT;
                        o_gnt   <= pick;
                        gnt_idx <= pick_idx;
                        ptr     <= (pick_idx == IW'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
                        o_busy  <= 1'b1;
                    end else begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Shared register: commits on the edge that ends GRANT.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_q     <= '0;
            o_owner <= '0;
            o_valid <= 1'b0;
        end else if (wr_en) begin
            o_q     <= i_data[gnt_idx*BW_DATA +: BW_DATA];
            o_owner <= gnt_idx;
            o_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Scoreboard bench for reg_wr_arbiter: a timing-level model predicts each
// write (grant edge, ack edge, data); a monitor checks DUT outputs every cycle.
module tb_reg_wr_arbiter;

    logic             i_clk;
    logic             i_rstn;
    logic [3:0]       i_req;
    logic [3:0][31:0] i_data;
    logic [3:0]       o_gnt;
    logic [3:0]       o_ack;
    logic [31:0]      o_q;
    logic [1:0]       o_owner;
    logic             o_valid;
    logic             o_busy;

    reg_wr_arbiter #(.BW_DATA(32), .N_REQ(4)) dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_req   (i_req),
        .i_data  (i_data),
        .o_gnt   (o_gnt),
        .o_ack   (o_ack),
        .o_q     (o_q),
        .o_owner (o_owner),
        .o_valid (o_valid),
        .o_busy  (o_busy)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        int          c;      // edge at which the winner was chosen
        logic [1:0]  idx;
        logic [31:0] data;
        int          epoch;  // reset count when predicted; stale after a reset
    } txn_t;

    txn_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   rst_cnt  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(negedge i_rstn);
        rst_cnt++;
    end

    // Reference model: a write chosen at edge c shows its grant after c, its
    // ack and data after c+1, and the next choice is made at c+2 (excluding
    // the requester just acked). With no winner, try again next edge.
    logic [1:0] m_p = 2'd0;
    logic [1:0] last_w = 2'd0;
    logic [1:0] cand;
    logic [3:0] el;
    int         last_c = -10;
    int         next_arb = 1;
    bit         found;
    initial forever begin
        @(posedge i_clk or negedge i_rstn);
        if (!i_rstn) begin
            m_p      = 2'd0;
            last_c   = -10;
            next_arb = cyc + 1;
        end else begin
            cyc++;
            if (cyc >= next_arb) begin
                el = i_req;
                if (cyc == last_c + 2) el[last_w] = 1'b0;
                found = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    cand = m_p + 2'(j);
                    if (!found && el[cand]) begin
                        found  = 1'b1;
                        last_w = cand;
                    end
                end
                if (found) begin
                    sb.push_back('{cyc, last_w, i_data[last_w], rst_cnt});
                    m_p      = last_w + 2'd1;
                    last_c   = cyc;
                    next_arb = cyc + 2;
                end else begin
                    next_arb = cyc + 1;
                end
            end
        end
    end

    // Monitor: compares outputs each falling edge against the scoreboard head.
    int          rd = 0;
    int          seen_rst = 0;
    logic [31:0] exp_q = '0;
    logic [1:0]  exp_owner = '0;
    logic        exp_valid = 1'b0;
    logic [3:0]  eg, ea;
    initial forever begin
        @(negedge i_clk);
        if (rst_cnt != seen_rst) begin
            exp_q     = '0;
            exp_owner = '0;
            exp_valid = 1'b0;
            seen_rst  = rst_cnt;
        end
        if (!i_rstn) begin
            chk("rst_gnt", o_gnt, 0);
            chk("rst_ack", o_ack, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_q", o_q, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_owner", o_owner, 0);
        end else begin
            while (rd < sb.size() && sb[rd].epoch != rst_cnt) rd++;
            eg = '0;
            ea = '0;
            if (rd < sb.size()) begin
                if (cyc == sb[rd].c) begin
                    eg = 4'b1 << sb[rd].idx;
                end else if (cyc == sb[rd].c + 1) begin
                    ea        = 4'b1 << sb[rd].idx;
                    exp_q     = sb[rd].data;
                    exp_owner = sb[rd].idx;
                    exp_valid = 1'b1;
                    rd++;
                end else if (cyc > sb[rd].c + 1) begin
                    chk("missed_write", 1, 0);
                    rd++;
                end
            end
            chk("gnt", o_gnt, eg);
            chk("ack", o_ack, ea);
            chk("busy", o_busy, (eg | ea) != 0);
            chk("q", o_q, exp_q);
            chk("owner", o_owner, exp_owner);
            chk("valid", o_valid, exp_valid);
        end
    end

    // Requester agents: 0 idle, 1 requesting, 2 dropped early awaiting ack,
    // 3 holding one cycle past ack.
    int st[4];

    task automatic agent(input int raise_pct, input int late_pct, input int early_pct);
        for (int k = 0; k < 4; k++) begin
            case (st[k])
                1: begin
                    if (o_ack[k[1:0]]) begin
                        if (int'($urandom_range(99)) < late_pct) st[k] = 3;
                        else begin
                            i_req[k[1:0]] = 1'b0;
                            st[k] = 0;
                        end
                    end else if (o_gnt[k[1:0]] && int'($urandom_range(99)) < early_pct) begin
                        i_req[k[1:0]] = 1'b0;
                        st[k] = 2;
                    end
                end
                2: if (o_ack[k[1:0]]) st[k] = 0;
                3: begin
                    i_req[k[1:0]] = 1'b0;
                    st[k] = 0;
                end
                default: if (int'($urandom_range(99)) < raise_pct) begin
                    i_req[k[1:0]]  = 1'b1;
                    i_data[k[1:0]] = $urandom;
                    st[k] = 1;
                end
            endcase
        end
    endtask

    task automatic run(input int n, input int raise_pct, input int late_pct, input int early_pct);
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            agent(raise_pct, late_pct, early_pct);
        end
    endtask

    task automatic raise(input logic [3:0] m);
        for (int k = 0; k < 4; k++) if (m[k[1:0]]) begin
            i_req[k[1:0]]  = 1'b1;
            i_data[k[1:0]] = $urandom;
            st[k] = 1;
        end
    endtask

    int pend;

    initial begin
        i_rstn = 1'b1;
        i_req  = '0;
        i_data = '0;
        foreach (st[k]) st[k] = 0;
        #1 i_rstn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            i_req = 4'($urandom);
            for (int k = 0; k < 4; k++) i_data[k[1:0]] = $urandom;
        end
        @(negedge i_clk);
        i_req = '0;
        #2 i_rstn = 1'b1;
        run(2, 0, 0, 0);

        // Single write from requester 2.
        raise(4'b0100);
        i_data[2] = 32'hDEADBEEF;
        run(4, 0, 0, 0);
        chk("single_q", o_q, 32'hDEADBEEF);
        chk("single_owner", o_owner, 2);
        chk("single_valid", o_valid, 1);

        // All four continuously, then a second round.
        raise(4'b1111);
        run(10, 0, 0, 0);
        raise(4'b1111);
        run(10, 0, 0, 0);

        // Early drop during GRANT, then late drop after ACK.
        raise(4'b0111);
        run(8, 0, 0, 100);
        raise(4'b0111);
        run(8, 0, 100, 0);

        // Pointer wrap: 3, then 0 before 3.
        raise(4'b1000);
        run(3, 0, 0, 0);
        raise(4'b1001);
        run(6, 0, 0, 0);

        // Reset during GRANT to requester 3.
        @(negedge i_clk);
        raise(4'b1000);
        i_data[3] = 32'h1234;
        for (int i = 0; i < 10 && !o_gnt[3]; i++) @(negedge i_clk);
        chk("gnt3_seen", o_gnt[3], 1);
        #1 i_rstn = 1'b0;
        #1;
        chk("async_gnt", o_gnt, 0);
        chk("async_ack", o_ack, 0);
        chk("async_busy", o_busy, 0);
        chk("async_q", o_q, 0);
        chk("async_valid", o_valid, 0);
        #1;
        i_req = '0;
        foreach (st[k]) st[k] = 0;
        i_rstn = 1'b1;
        @(negedge i_clk);
        raise(4'b0110);
        run(6, 0, 0, 0);

        // Random traffic, then drain.
        run(800, 30, 20, 15);
        run(14, 0, 0, 0);

        pend = 0;
        foreach (sb[i]) if (i >= rd && sb[i].epoch == rst_cnt) pend++;
        chk("sb_drained", pend, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
